// File: rtl/mmu_pkg.sv
// Shared types and helpers for the tiled matmul scheduler: FSM state encoding,
// engine result width and the saturating accumulate used per tile element.
package mmu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } mmu_state_e;

    localparam int ENG_W   = 16;
    // Working width of sat_add; any ACC_W up to this value is supported.
    localparam int ACC_MAX = 32;

    // Index width for a loop of n tiles, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add clamped to [-2^(acc_w-1), 2^(acc_w-1)-1]; the carry bit keeps the raw sum exact.
    function automatic logic signed [ACC_MAX-1:0] sat_add(
        input logic signed [ACC_MAX-1:0] acc,
        input logic signed [ACC_MAX-1:0] x,
        input int                        acc_w
    );
        logic signed [ACC_MAX:0] sum;
        logic signed [ACC_MAX:0] max_v;
        logic signed [ACC_MAX:0] min_v;
        sum   = {acc[ACC_MAX-1], acc} + {x[ACC_MAX-1], x};
        max_v = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
        min_v = -max_v - 33'sd1;
        if (sum > max_v) begin
            sat_add = max_v[ACC_MAX-1:0];
        end else if (sum < min_v) begin
            sat_add = min_v[ACC_MAX-1:0];
        end else begin
            sat_add = sum[ACC_MAX-1:0];
        end
    endfunction

endpackage

// File: rtl/mmu_tile_accumulator.sv
// Four signed accumulators for one 2x2 output tile: load on the first inner
// tile, saturating accumulate on later ones, hold otherwise.
module mmu_tile_accumulator
    import mmu_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_accum,
    input  logic [ENG_W-1:0] i_c00,
    input  logic [ENG_W-1:0] i_c01,
    input  logic [ENG_W-1:0] i_c10,
    input  logic [ENG_W-1:0] i_c11,
    output logic [ACC_W-1:0] o_acc00,
    output logic [ACC_W-1:0] o_acc01,
    output logic [ACC_W-1:0] o_acc10,
    output logic [ACC_W-1:0] o_acc11
);

    logic        [ENG_W-1:0] w_c       [4];
    logic signed [ACC_W-1:0] w_acc_nxt [4];
    logic signed [ACC_W-1:0] r_acc     [4];

    assign w_c[0] = i_c00;
    assign w_c[1] = i_c01;
    assign w_c[2] = i_c10;
    assign w_c[3] = i_c11;

    // Next accumulator value per element; engine data is sign-extended first.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            w_acc_nxt[e] = r_acc[e];
            if (i_load) begin
                w_acc_nxt[e] = ACC_W'(signed'(w_c[e]));
            end else if (i_accum) begin
                w_acc_nxt[e] = ACC_W'(sat_add(ACC_MAX'(r_acc[e]),
                                              ACC_MAX'(signed'(w_c[e])), ACC_W));
            end else begin
                w_acc_nxt[e] = r_acc[e];
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 4; e++) begin
                r_acc[e] <= {ACC_W{1'b0}};
            end
        end else begin
            for (int e = 0; e < 4; e++) begin
                r_acc[e] <= w_acc_nxt[e];
            end
        end
    end

    assign o_acc00 = r_acc[0];
    assign o_acc01 = r_acc[1];
    assign o_acc10 = r_acc[2];
    assign o_acc11 = r_acc[3];

endmodule

// File: rtl/mmu_tile_scheduler.sv
// Walks the i/j/k tile loops for the 2x2 systolic engine, accumulates each
// output tile over k and hands finished tiles to the host.
module mmu_tile_scheduler
    import mmu_pkg::*;
#(
    parameter  int TILES_M = 2,
    parameter  int TILES_N = 2,
    parameter  int TILES_K = 2,
    parameter  int ACC_W   = 18,
    localparam int MW      = idx_width(TILES_M),
    localparam int NW      = idx_width(TILES_N),
    localparam int KW      = idx_width(TILES_K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             eng_req,
    input  logic             eng_ack,
    output logic [MW-1:0]    eng_a_row,
    output logic [KW-1:0]    eng_a_col,
    output logic [NW-1:0]    eng_b_col,
    input  logic             eng_done,
    input  logic [ENG_W-1:0] eng_c00,
    input  logic [ENG_W-1:0] eng_c01,
    input  logic [ENG_W-1:0] eng_c10,
    input  logic [ENG_W-1:0] eng_c11,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MW-1:0]    res_row,
    output logic [NW-1:0]    res_col,
    output logic [ACC_W-1:0] res_c00,
    output logic [ACC_W-1:0] res_c01,
    output logic [ACC_W-1:0] res_c10,
    output logic [ACC_W-1:0] res_c11
);

    mmu_state_e    r_state;
    mmu_state_e    w_state_nxt;
    logic [MW-1:0] r_i;
    logic [NW-1:0] r_j;
    logic [KW-1:0] r_k;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_eng_req;
    logic          r_res_valid;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_eng_req_nxt;
    logic          w_res_valid_nxt;
    logic          w_start_ok;
    logic          w_abort_run;
    logic          w_capture;
    logic          w_accept;
    logic          w_err_set;
    logic          w_i_last;
    logic          w_j_last;
    logic          w_k_last;

    assign w_start_ok  = (r_state == IDLE) && start && !abort;
    assign w_abort_run = (r_state != IDLE) && abort;
    assign w_capture   = (r_state == WAIT) && eng_done && !abort;
    assign w_accept    = (r_state == EMIT) && res_ready && !abort;
    // A result pulse is only legal while waiting for it; an abort cycle leaves err alone.
    assign w_err_set   = eng_done && (r_state != WAIT) && !w_abort_run;
    assign w_i_last    = (r_i == MW'(TILES_M - 1));
    assign w_j_last    = (r_j == NW'(TILES_N - 1));
    assign w_k_last    = (r_k == KW'(TILES_K - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every non-idle state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort_run) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = w_start_ok ? ISSUE : IDLE;
                ISSUE:   w_state_nxt = eng_ack ? WAIT : ISSUE;
                WAIT:    w_state_nxt = eng_done ? ACCUM : WAIT;
                ACCUM:   w_state_nxt = w_k_last ? EMIT : ISSUE;
                EMIT: begin
                    if (res_ready) begin
                        w_state_nxt = (w_i_last && w_j_last) ? DONE : ISSUE;
                    end else begin
                        w_state_nxt = EMIT;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output decode from the next state so the flops below present it with the state.
    always_comb begin
        w_busy_nxt      = (w_state_nxt != IDLE);
        w_eng_req_nxt   = 1'b0;
        w_res_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        case (w_state_nxt)
            ISSUE:   w_eng_req_nxt   = 1'b1;
            EMIT:    w_res_valid_nxt = 1'b1;
            DONE:    w_done_nxt      = 1'b1;
            default: w_eng_req_nxt   = 1'b0;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_eng_req   <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_eng_req   <= w_eng_req_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Tile loop counters: k inner, j middle, i outer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= {MW{1'b0}};
            r_j <= {NW{1'b0}};
            r_k <= {KW{1'b0}};
        end else if (w_start_ok || w_abort_run) begin
            r_i <= {MW{1'b0}};
            r_j <= {NW{1'b0}};
            r_k <= {KW{1'b0}};
        end else if ((r_state == ACCUM) && !w_k_last) begin
            r_k <= r_k + KW'(1);
        end else if (w_accept) begin
            r_k <= {KW{1'b0}};
            if (w_j_last) begin
                r_j <= {NW{1'b0}};
                r_i <= w_i_last ? {MW{1'b0}} : (r_i + MW'(1));
            end else begin
                r_j <= r_j + NW'(1);
            end
        end else begin
            r_k <= r_k;
        end
    end

    // Sticky protocol error; a fresh accepted start clears it unless a new violation coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    mmu_tile_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_capture && (r_k == {KW{1'b0}})),
        .i_accum (w_capture && (r_k != {KW{1'b0}})),
        .i_c00   (eng_c00),
        .i_c01   (eng_c01),
        .i_c10   (eng_c10),
        .i_c11   (eng_c11),
        .o_acc00 (res_c00),
        .o_acc01 (res_c01),
        .o_acc10 (res_c10),
        .o_acc11 (res_c11)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign eng_req   = r_eng_req;
    assign res_valid = r_res_valid;
    assign eng_a_row = r_i;
    assign eng_a_col = r_k;
    assign eng_b_col = r_j;
    assign res_row   = r_i;
    assign res_col   = r_j;

endmodule
